// File: rtl/sfx_voice_mixer.sv
// Multi-voice sound-effect player: Avalon-programmed sound table, per-voice one-shot/loop playback
// from a shared synchronous ROM, saturating mono mix to the DAC once per codec advance strobe.
module sfx_voice_mixer #(
  parameter int NUM_VOICES = 2,
  parameter int NUM_SOUNDS = 4,
  parameter int DATA_W     = 16,
  parameter int ROM_AW     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  chipselect,
  input  logic                  read,
  input  logic                  write,
  input  logic [7:0]            address,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic                  advance,
  output logic [ROM_AW-1:0]     rom_addr,
  input  logic [DATA_W-1:0]     rom_data,
  output logic [DATA_W-1:0]     dac_left,
  output logic [DATA_W-1:0]     dac_right,
  output logic [NUM_VOICES-1:0] voice_active,
  output logic                  irq
);

  localparam int VIW   = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = DATA_W + $clog2(NUM_VOICES) + 1;

  // state   | meaning
  // S_IDLE  | wait for advance; hold dac at 0 while disabled
  // S_APPLY | consume pending triggers/stops, clear accumulator
  // S_ISSUE | present ROM address for voice vidx
  // S_CAPT  | accumulate ROM sample for voice vidx
  // S_OUT   | saturate to dac, step offsets, flag finished voices
  typedef enum logic [2:0] {S_IDLE, S_APPLY, S_ISSUE, S_CAPT, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [VIW-1:0]        vidx_q, vidx_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [DATA_W-1:0]     dac_q, dac_d;
  logic [31:0]           rd_q, rd_d;
  logic [1:0]            ctrl_q, ctrl_d;
  logic                  overrun_q, overrun_d;
  logic [NUM_VOICES-1:0] done_q, done_d, active_q, active_d, v_loop_q, v_loop_d;
  logic [NUM_VOICES-1:0] pend_q, pend_d, pend_stop_q, pend_stop_d, pend_loop_q, pend_loop_d;
  logic [3:0]            pend_snd_q [NUM_VOICES];
  logic [3:0]            pend_snd_d [NUM_VOICES];
  logic [ROM_AW-1:0]     start_tab_q [NUM_SOUNDS];
  logic [ROM_AW-1:0]     start_tab_d [NUM_SOUNDS];
  logic [ROM_AW-1:0]     len_tab_q [NUM_SOUNDS];
  logic [ROM_AW-1:0]     len_tab_d [NUM_SOUNDS];
  logic [ROM_AW-1:0]     v_start_q [NUM_VOICES];
  logic [ROM_AW-1:0]     v_start_d [NUM_VOICES];
  logic [ROM_AW-1:0]     v_len_q [NUM_VOICES];
  logic [ROM_AW-1:0]     v_len_d [NUM_VOICES];
  logic [ROM_AW-1:0]     v_off_q [NUM_VOICES];
  logic [ROM_AW-1:0]     v_off_d [NUM_VOICES];

  logic [NUM_VOICES-1:0] done_set;
  logic                  ovr_set;
  logic [ROM_AW-1:0]     snd_start, snd_len;
  logic [ACC_W-DATA_W:0] acc_hi;
  logic                  wr_en, rd_en;

  always_comb begin
    state_d     = state_q;
    vidx_d      = vidx_q;
    acc_d       = acc_q;
    dac_d       = dac_q;
    rd_d        = rd_q;
    ctrl_d      = ctrl_q;
    overrun_d   = overrun_q;
    done_d      = done_q;
    active_d    = active_q;
    v_loop_d    = v_loop_q;
    pend_d      = pend_q;
    pend_stop_d = pend_stop_q;
    pend_loop_d = pend_loop_q;
    pend_snd_d  = pend_snd_q;
    start_tab_d = start_tab_q;
    len_tab_d   = len_tab_q;
    v_start_d   = v_start_q;
    v_len_d     = v_len_q;
    v_off_d     = v_off_q;
    done_set    = '0;
    ovr_set     = 1'b0;
    snd_start   = '0;
    snd_len     = '0;
    acc_hi      = acc_q[ACC_W-1:DATA_W-1];
    rom_addr    = '0;
    wr_en       = chipselect & write;
    rd_en       = chipselect & read;

    if (advance && state_q != S_IDLE) ovr_set = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (!ctrl_q[0]) dac_d = '0;
        else if (advance) state_d = S_APPLY;
      end
      S_APPLY: begin
        acc_d   = '0;
        vidx_d  = '0;
        state_d = S_ISSUE;
        for (int v = 0; v < NUM_VOICES; v++) begin
          snd_start = '0;
          snd_len   = '0;
          for (int s = 0; s < NUM_SOUNDS; s++) begin
            if (int'(pend_snd_q[v]) == s) begin
              snd_start = start_tab_q[s];
              snd_len   = len_tab_q[s];
            end
          end
          if (pend_q[v]) begin
            pend_d[v] = 1'b0;
            if (pend_stop_q[v] || snd_len == '0) begin
              active_d[v] = 1'b0;
            end else begin
              v_start_d[v] = snd_start;
              v_len_d[v]   = snd_len;
              v_off_d[v]   = '0;
              v_loop_d[v]  = pend_loop_q[v];
              active_d[v]  = 1'b1;
            end
          end
        end
      end
      S_ISSUE: begin
        rom_addr = v_start_q[vidx_q] + v_off_q[vidx_q];
        state_d  = S_CAPT;
      end
      S_CAPT: begin
        if (active_q[vidx_q])
          acc_d = acc_q + {{(ACC_W-DATA_W){rom_data[DATA_W-1]}}, rom_data};
        if (vidx_q == VIW'(NUM_VOICES - 1)) begin
          state_d = S_OUT;
        end else begin
          vidx_d  = vidx_q + 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_OUT: begin
        // In range iff every bit above the DATA_W-1 sign bit matches it
        if ((&acc_hi) || !(|acc_hi)) dac_d = acc_q[DATA_W-1:0];
        else if (acc_q[ACC_W-1])     dac_d = {1'b1, {(DATA_W-1){1'b0}}};
        else                         dac_d = {1'b0, {(DATA_W-1){1'b1}}};
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (active_q[v]) begin
            if (v_off_q[v] == v_len_q[v] - ROM_AW'(1)) begin
              if (v_loop_q[v]) begin
                v_off_d[v] = '0;
              end else begin
                active_d[v] = 1'b0;
                done_set[v] = 1'b1;
              end
            end else begin
              v_off_d[v] = v_off_q[v] + ROM_AW'(1);
            end
          end
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Bus writes come after APPLY so a TRIG landing in the APPLY cycle stays pending
    if (wr_en) begin
      case (address)
        8'h00: ctrl_d = writedata[1:0];
        8'h01: begin
          for (int v = 0; v < NUM_VOICES; v++) begin
            if (int'(writedata[2:0]) == v &&
                (writedata[17] || int'(writedata[11:8]) < NUM_SOUNDS)) begin
              pend_d[v]      = 1'b1;
              pend_stop_d[v] = writedata[17];
              pend_loop_d[v] = writedata[16];
              pend_snd_d[v]  = writedata[11:8];
            end
          end
        end
        8'h02: done_d = done_q & ~writedata[NUM_VOICES-1:0];
        8'h03: if (writedata[8]) overrun_d = 1'b0;
        default: begin
          for (int s = 0; s < NUM_SOUNDS; s++) begin
            if (address == 8'(16 + 2*s))      start_tab_d[s] = writedata[ROM_AW-1:0];
            else if (address == 8'(17 + 2*s)) len_tab_d[s]   = writedata[ROM_AW-1:0];
          end
        end
      endcase
    end

    if (rd_en) begin
      rd_d = '0;
      case (address)
        8'h00: rd_d[1:0] = ctrl_q;
        8'h02: rd_d[NUM_VOICES-1:0] = done_q;
        8'h03: begin
          rd_d[NUM_VOICES-1:0] = active_q;
          rd_d[8]              = overrun_q;
        end
        default: begin
          for (int s = 0; s < NUM_SOUNDS; s++) begin
            if (address == 8'(16 + 2*s))      rd_d[ROM_AW-1:0] = start_tab_q[s];
            else if (address == 8'(17 + 2*s)) rd_d[ROM_AW-1:0] = len_tab_q[s];
          end
        end
      endcase
    end

    done_d    = done_d | done_set;
    overrun_d = overrun_d | ovr_set;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      vidx_q      <= '0;
      acc_q       <= '0;
      dac_q       <= '0;
      rd_q        <= '0;
      ctrl_q      <= '0;
      overrun_q   <= 1'b0;
      done_q      <= '0;
      active_q    <= '0;
      v_loop_q    <= '0;
      pend_q      <= '0;
      pend_stop_q <= '0;
      pend_loop_q <= '0;
      pend_snd_q  <= '{default: '0};
      start_tab_q <= '{default: '0};
      len_tab_q   <= '{default: '0};
      v_start_q   <= '{default: '0};
      v_len_q     <= '{default: '0};
      v_off_q     <= '{default: '0};
    end else begin
      state_q     <= state_d;
      vidx_q      <= vidx_d;
      acc_q       <= acc_d;
      dac_q       <= dac_d;
      rd_q        <= rd_d;
      ctrl_q      <= ctrl_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      active_q    <= active_d;
      v_loop_q    <= v_loop_d;
      pend_q      <= pend_d;
      pend_stop_q <= pend_stop_d;
      pend_loop_q <= pend_loop_d;
      pend_snd_q  <= pend_snd_d;
      start_tab_q <= start_tab_d;
      len_tab_q   <= len_tab_d;
      v_start_q   <= v_start_d;
      v_len_q     <= v_len_d;
      v_off_q     <= v_off_d;
    end
  end

  assign readdata     = rd_q;
  assign dac_left     = dac_q;
  assign dac_right    = dac_q;
  assign voice_active = active_q;
  assign irq          = ctrl_q[1] & (|done_q);

endmodule

// File: tb/tb_sfx_voice_mixer.sv
// Scoreboard bench for sfx_voice_mixer: a per-frame reference model pushes timed expectations,
// a monitor process compares them against the DUT pins at their due cycle.
module tb_sfx_voice_mixer;
  localparam int NV = 2;
  localparam int NS = 4;
  localparam int K_DAC = 0, K_RD = 1, K_VA = 2, K_IRQ = 3;

  logic        clk = 1'b0;
  logic        reset, chipselect, read, write, advance;
  logic [7:0]  address;
  logic [31:0] writedata, readdata;
  logic [15:0] rom_addr, rom_data, dac_left, dac_right;
  logic [NV-1:0] voice_active;
  logic        irq;

  sfx_voice_mixer #(.NUM_VOICES(NV), .NUM_SOUNDS(NS), .DATA_W(16), .ROM_AW(16)) dut (
    .clk(clk), .reset(reset), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .advance(advance),
    .rom_addr(rom_addr), .rom_data(rom_data), .dac_left(dac_left), .dac_right(dac_right),
    .voice_active(voice_active), .irq(irq));

  always #10 clk = ~clk;

  logic [15:0] rom_mem [0:65535];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int kind; int due; logic [31:0] exp; string name;} exp_t;
  exp_t sbq[$];
  int errs = 0, checks = 0;

  // reference model state
  int m_start[NS], m_len[NS];
  int m_ctrl, m_done, m_ovr;
  int m_act[NV], m_vs[NV], m_vl[NV], m_off[NV], m_loop[NV];
  int m_pv[NV], m_pstop[NV], m_ploop[NV], m_psnd[NV];

  function automatic void push(int kind, int due, logic [31:0] exp, string name);
    exp_t e;
    e.kind = kind; e.due = due; e.exp = exp; e.name = name;
    sbq.push_back(e);
  endfunction

  function automatic void model_reset();
    m_ctrl = 0; m_done = 0; m_ovr = 0;
    for (int s = 0; s < NS; s++) begin m_start[s] = 0; m_len[s] = 0; end
    for (int v = 0; v < NV; v++) begin
      m_act[v] = 0; m_vs[v] = 0; m_vl[v] = 0; m_off[v] = 0; m_loop[v] = 0;
      m_pv[v] = 0; m_pstop[v] = 0; m_ploop[v] = 0; m_psnd[v] = 0;
    end
  endfunction

  function automatic void model_trig(logic [31:0] d);
    int v = int'(d[2:0]);
    int s = int'(d[11:8]);
    if (v < NV && (d[17] || s < NS)) begin
      m_pv[v] = 1; m_pstop[v] = int'(d[17]); m_ploop[v] = int'(d[16]); m_psnd[v] = s;
    end
  endfunction

  // one enabled frame: apply pending, mix, saturate, advance voices
  function automatic logic [31:0] model_frame();
    int sum = 0;
    for (int v = 0; v < NV; v++) begin
      if (m_pv[v]) begin
        m_pv[v] = 0;
        if (m_pstop[v] || m_len[m_psnd[v]] == 0) m_act[v] = 0;
        else begin
          m_vs[v] = m_start[m_psnd[v]]; m_vl[v] = m_len[m_psnd[v]];
          m_off[v] = 0; m_loop[v] = m_ploop[v]; m_act[v] = 1;
        end
      end
    end
    for (int v = 0; v < NV; v++)
      if (m_act[v]) sum += int'($signed(rom_mem[(m_vs[v] + m_off[v]) % 65536]));
    if (sum > 32767) sum = 32767;
    if (sum < -32768) sum = -32768;
    for (int v = 0; v < NV; v++) begin
      if (m_act[v]) begin
        if (m_off[v] == m_vl[v] - 1) begin
          if (m_loop[v]) m_off[v] = 0;
          else begin m_act[v] = 0; m_done |= (1 << v); end
        end else m_off[v]++;
      end
    end
    return 32'(sum) & 32'hFFFF;
  endfunction

  function automatic int act_mask();
    int m = 0;
    for (int v = 0; v < NV; v++) if (m_act[v]) m |= (1 << v);
    return m;
  endfunction

  function automatic logic [31:0] model_read(int a);
    if (a == 0) return 32'(m_ctrl);
    if (a == 2) return 32'(m_done);
    if (a == 3) return 32'(act_mask() | (m_ovr << 8));
    if (a >= 16 && a < 16 + 2*NS) return ((a - 16) % 2) ? 32'(m_len[(a-16)/2]) : 32'(m_start[(a-16)/2]);
    return 32'h0;
  endfunction

  task automatic wr_raw(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    int n;
    @(negedge clk);
    n = cyc;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    case (a)
      8'h00: begin m_ctrl = int'(d[1:0]); if (!d[0]) push(K_DAC, n + 2, 0, "dac_disabled"); end
      8'h01: model_trig(d);
      8'h02: m_done &= ~int'(d[NV-1:0]);
      8'h03: if (d[8]) m_ovr = 0;
      default: if (a >= 16 && a < 16 + 2*NS) begin
        if ((a - 16) % 2) m_len[(a-16)/2] = int'(d[15:0]);
        else m_start[(a-16)/2] = int'(d[15:0]);
      end
    endcase
    @(negedge clk);
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input string name);
    @(negedge clk);
    chipselect = 1'b1; read = 1'b1; address = a;
    push(K_RD, cyc + 1, model_read(int'(a)), name);
    @(negedge clk);
    chipselect = 1'b0; read = 1'b0;
  endtask

  task automatic adv(input int gap);
    int n;
    @(negedge clk);
    n = cyc;
    advance = 1'b1;
    if (m_ctrl & 1) push(K_DAC, n + 7, model_frame(), "dac_frame");
    else push(K_DAC, n + 2, 0, "dac_ignored_adv");
    @(negedge clk);
    advance = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic chk_pins();
    @(negedge clk);
    push(K_VA, cyc + 1, 32'(act_mask()), "voice_active");
    push(K_IRQ, cyc + 1, ((m_ctrl & 2) && m_done != 0) ? 32'h1 : 32'h0, "irq");
    @(negedge clk);
  endtask

  // monitor: compare every expectation whose due cycle has arrived
  initial begin
    forever begin
      @(negedge clk);
      for (int i = sbq.size() - 1; i >= 0; i--) begin
        if (sbq[i].due <= cyc) begin
          logic ok;
          logic [31:0] act;
          case (sbq[i].kind)
            K_DAC:   begin act = {dac_right, dac_left};
                       ok = (dac_left == sbq[i].exp[15:0]) && (dac_right == sbq[i].exp[15:0]); end
            K_RD:    begin act = readdata; ok = (readdata == sbq[i].exp); end
            K_VA:    begin act = 32'(voice_active); ok = (voice_active == sbq[i].exp[NV-1:0]); end
            default: begin act = 32'(irq); ok = (irq == sbq[i].exp[0]); end
          endcase
          if (sbq[i].due < cyc) ok = 1'b0;
          checks++;
          if (!ok) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d due %0d)",
                     sbq[i].name, act, sbq[i].exp, cyc, sbq[i].due);
          end
          sbq.delete(i);
        end
      end
    end
  end

  initial begin
    int n;
    logic [31:0] d, hold;
    for (int i = 0; i < 65536; i++) rom_mem[i] = 16'($urandom);
    reset = 1'b1; chipselect = 1'b0; read = 1'b0; write = 1'b0; advance = 1'b0;
    address = '0; writedata = '0;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    // T1 reset state
    push(K_DAC, cyc + 1, 0, "reset_dac");
    push(K_RD, cyc + 1, 0, "reset_readdata");
    chk_pins();
    rd(8'h10, "reset_start0");

    // T2 one-shot
    rom_mem[100] = 16'd5; rom_mem[101] = 16'd6; rom_mem[102] = 16'd7;
    wr(8'h10, 100); wr(8'h11, 3); wr(8'h00, 1);
    wr(8'h01, 32'h0000_0000);
    repeat (4) adv(8);
    rd(8'h02, "oneshot_done");

    // T3 loop then stop
    wr(8'h02, 3);
    rom_mem[200] = 16'd10; rom_mem[201] = 16'd20;
    wr(8'h12, 200); wr(8'h13, 2);
    wr(8'h01, 32'h0001_0100);
    repeat (5) adv(8);
    wr(8'h01, 32'h0002_0000);
    adv(8);
    rd(8'h02, "loop_stop_done");

    // T4 saturation
    rom_mem[300] = 16'h7000; rom_mem[301] = 16'h6000;
    wr(8'h14, 300); wr(8'h15, 1); wr(8'h16, 301); wr(8'h17, 1);
    wr(8'h01, 32'h0000_0200); wr(8'h01, 32'h0000_0301);
    adv(8);
    rom_mem[300] = 16'h9000; rom_mem[301] = 16'h9000;
    wr(8'h01, 32'h0000_0200); wr(8'h01, 32'h0000_0301);
    adv(8);

    // T5 overrun: second advance lands mid-frame and must be ignored
    wr(8'h01, 32'h0001_0100);
    @(negedge clk);
    n = cyc;
    advance = 1'b1;
    hold = model_frame();
    push(K_DAC, n + 7, hold, "overrun_dac");
    push(K_DAC, n + 16, hold, "overrun_dac_once");
    @(negedge clk); advance = 1'b0;
    @(negedge clk); advance = 1'b1;
    m_ovr = 1;
    @(negedge clk); advance = 1'b0;
    repeat (16) @(negedge clk);
    rd(8'h03, "overrun_stat");
    wr(8'h03, 32'h100);
    rd(8'h03, "overrun_clear");
    wr(8'h15, 0);
    wr(8'h01, 32'h0000_0200);
    adv(8);
    rd(8'h03, "len0_stat");
    wr(8'h01, 32'h0002_0005);
    adv(8);
    rd(8'h03, "bad_voice_stat");
    // disable freezes playback, keeps pending triggers
    wr(8'h01, 32'h0001_0101);
    adv(8);
    wr(8'h00, 0);
    adv(8);
    wr(8'h01, 32'h0001_0100);
    wr(8'h00, 1);
    adv(8);
    chk_pins();

    // T6 W1C DONE racing the set: set wins
    wr(8'h01, 32'h0002_0000); wr(8'h01, 32'h0002_0001);
    adv(8);
    wr(8'h02, 3);
    wr(8'h01, 32'h0000_0001);
    adv(8); adv(8);
    @(negedge clk);
    n = cyc;
    advance = 1'b1;
    push(K_DAC, n + 7, model_frame(), "race_dac");
    @(negedge clk); advance = 1'b0;
    repeat (4) @(negedge clk);
    wr_raw(8'h02, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    rd(8'h02, "race_done_set_wins");
    // retrigger in the last-sample frame
    wr(8'h02, 3);
    wr(8'h01, 32'h0000_0100);
    adv(8);
    wr(8'h01, 32'h0000_0100);
    adv(8);
    rd(8'h02, "retrig_no_done");
    adv(8);
    rd(8'h02, "retrig_done_later");
    wr(8'h00, 3);
    chk_pins();
    wr(8'h02, 3);
    chk_pins();

    // randomized traffic
    for (int s = 0; s < NS; s++) begin
      wr(8'(16 + 2*s), $urandom_range(0, 65535));
      wr(8'(17 + 2*s), $urandom_range(1, 6));
    end
    wr(8'h00, 1);
    for (int it = 0; it < 250; it++) begin
      int op = $urandom_range(0, 99);
      if (op < 40) adv(7 + $urandom_range(0, 3));
      else if (op < 65) begin
        d = 32'($urandom_range(0, 3)) | (32'($urandom_range(0, 5)) << 8) |
            (32'($urandom_range(0, 1)) << 16) | (($urandom_range(0, 99) < 15) ? 32'h2_0000 : 32'h0);
        wr(8'h01, d);
      end
      else if (op < 73) begin
        int s = $urandom_range(0, NS - 1);
        if ($urandom_range(0, 1)) wr(8'(16 + 2*s), $urandom_range(0, 65535));
        else wr(8'(17 + 2*s), $urandom_range(0, 6));
      end
      else if (op < 85) rd(8'($urandom_range(0, 3) == 0 ? $urandom_range(16, 23) : $urandom_range(0, 3)), "rand_read");
      else if (op < 90) wr(8'h02, 32'($urandom_range(0, 3)));
      else if (op < 95) wr(8'h00, ($urandom_range(0, 99) < 80) ? 32'($urandom_range(0, 1) * 2 + 1) : 32'h0);
      else chk_pins();
    end

    for (int w = 0; w < 50 && sbq.size() != 0; w++) @(negedge clk);
    if (sbq.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
      errs += sbq.size();
      checks += sbq.size();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
